// File: rtl/csr_mfile_if.sv
// CSR access port between the execute stage and csr_mfile.
// Handshake: csr_valid_i qualifies one access in the cycle it is high. There is
// no ready; the CSR file always accepts. rdata_o and illegal_o answer
// combinationally in the same cycle, and any state change lands on the next edge.
interface csr_mfile_if #(
  parameter int XLEN = 32
);
  logic            csr_valid_i;
  logic [2:0]      funct3_i;
  logic [11:0]     addr_i;
  logic [4:0]      rs1_i;
  logic [XLEN-1:0] wdata_i;
  logic [XLEN-1:0] rdata_o;
  logic            illegal_o;

  modport master (
    output csr_valid_i, funct3_i, addr_i, rs1_i, wdata_i,
    input  rdata_o, illegal_o
  );

  modport slave (
    input  csr_valid_i, funct3_i, addr_i, rs1_i, wdata_i,
    output rdata_o, illegal_o
  );
endinterface

// File: rtl/csr_mfile.sv
// Machine-mode CSR file: Zicsr accesses, trap/MRET bookkeeping, 64-bit
// cycle/instret counters, interrupt synchronisation and prioritisation.
module csr_mfile #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h40000100,
  parameter bit          VECTORED = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  csr_mfile_if.slave      csr,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_val_i,
  input  logic            mret_i,
  input  logic            retire_i,
  input  logic            irq_ext_i,
  input  logic            irq_tmr_i,
  input  logic            irq_sw_i,
  output logic            irq_pending_o,
  output logic [XLEN-1:0] irq_cause_o,
  output logic [XLEN-1:0] trap_vector_o,
  output logic [XLEN-1:0] epc_o
);
  // On RV64 the MXL field moves to the top two bits and reads 2.
  localparam logic [63:0]      MISA64  = {2'b10, 36'd0, MISA_VAL[25:0]};
  localparam logic [XLEN-1:0]  MISA_RD = (XLEN == 32) ? XLEN'(MISA_VAL) : XLEN'(MISA64);
  localparam logic [XLEN-1:0]  MIE_MASK = XLEN'(32'h888);

  logic            r_st_mie, r_st_mpie;
  logic [XLEN-1:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic            r_cy_inh, r_ir_inh;
  logic [63:0]     r_cycle, r_instret;
  logic            r_irq_ext, r_irq_tmr, r_irq_sw;

  logic            w_known, w_ro, w_wr_try, w_illegal, w_we;
  logic [XLEN-1:0] w_old, w_new, w_mstatus, w_mip, w_pend, w_base;
  logic [3:0]      w_code;

  // Address decode, old-value mux, legality and the read-modify-write result.
  always_comb begin
    w_mstatus = '0;
    w_mstatus[12:11] = 2'b11;
    w_mstatus[7] = r_st_mpie;
    w_mstatus[3] = r_st_mie;
    w_mip = '0;
    w_mip[11] = r_irq_ext;
    w_mip[7]  = r_irq_tmr;
    w_mip[3]  = r_irq_sw;
    w_known = 1'b1;
    w_ro    = 1'b0;
    w_old   = '0;
    case (csr.addr_i)
      12'hF11, 12'hF12, 12'hF13: w_ro = 1'b1;
      12'hF14: begin w_ro = 1'b1; w_old = XLEN'(HART_ID); end
      12'h301: begin w_ro = 1'b1; w_old = MISA_RD; end
      12'h300: w_old = w_mstatus;
      12'h304: w_old = r_mie;
      12'h305: w_old = r_mtvec;
      12'h340: w_old = r_mscratch;
      12'h341: w_old = r_mepc;
      12'h342: w_old = r_mcause;
      12'h343: w_old = r_mtval;
      12'h344: w_old = w_mip;
      12'h320: begin w_old[0] = r_cy_inh; w_old[2] = r_ir_inh; end
      12'hB00: w_old = r_cycle[XLEN-1:0];
      12'hB02: w_old = r_instret[XLEN-1:0];
      12'hB80: begin w_known = (XLEN == 32); w_old = XLEN'(r_cycle[63:32]); end
      12'hB82: begin w_known = (XLEN == 32); w_old = XLEN'(r_instret[63:32]); end
      default: w_known = 1'b0;
    endcase
    // Set/clear forms with rs1=0 are pure reads and never count as writes.
    w_wr_try  = (csr.funct3_i[1:0] == 2'b01) || (csr.rs1_i != 5'd0);
    w_illegal = csr.csr_valid_i &&
                (!w_known || (csr.funct3_i[1:0] == 2'b00) || (w_ro && w_wr_try));
    w_we      = csr.csr_valid_i && !w_illegal && w_wr_try && !trap_i && !mret_i;
    case (csr.funct3_i[1:0])
      2'b01:   w_new = csr.wdata_i;
      2'b10:   w_new = w_old | csr.wdata_i;
      2'b11:   w_new = w_old & ~csr.wdata_i;
      default: w_new = w_old;
    endcase
    csr.rdata_o   = (csr.csr_valid_i && !w_illegal) ? w_old : '0;
    csr.illegal_o = w_illegal;
  end

  // Interrupt prioritisation (MEI > MSI > MTI) and trap target selection.
  always_comb begin
    w_pend = w_mip & r_mie;
    irq_pending_o = r_st_mie && (w_pend != '0);
    if (w_pend[11])     w_code = 4'd11;
    else if (w_pend[3]) w_code = 4'd3;
    else if (w_pend[7]) w_code = 4'd7;
    else                w_code = 4'd0;
    irq_cause_o = '0;
    if (irq_pending_o) begin
      irq_cause_o[XLEN-1] = 1'b1;
      irq_cause_o[3:0]    = w_code;
    end
    w_base = {r_mtvec[XLEN-1:2], 2'b00};
    if (r_mtvec[0] && irq_pending_o) trap_vector_o = w_base + XLEN'({w_code, 2'b00});
    else                             trap_vector_o = w_base;
    epc_o = r_mepc;
  end

  // Architectural registers: trap beats MRET beats a CSR write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_st_mie <= 1'b0; r_st_mpie <= 1'b0;
      r_mie <= '0; r_mtvec <= '0; r_mscratch <= '0;
      r_mepc <= '0; r_mcause <= '0; r_mtval <= '0;
      r_cy_inh <= 1'b0; r_ir_inh <= 1'b0;
    end else if (trap_i) begin
      r_mepc    <= {trap_pc_i[XLEN-1:2], 2'b00};
      r_mcause  <= trap_cause_i;
      r_mtval   <= trap_val_i;
      r_st_mpie <= r_st_mie;
      r_st_mie  <= 1'b0;
    end else if (mret_i) begin
      r_st_mie  <= r_st_mpie;
      r_st_mpie <= 1'b1;
    end else if (w_we) begin
      case (csr.addr_i)
        12'h300: begin r_st_mie <= w_new[3]; r_st_mpie <= w_new[7]; end
        12'h304: r_mie <= w_new & MIE_MASK;
        12'h305: r_mtvec <= {w_new[XLEN-1:2], 1'b0, w_new[0] & VECTORED};
        12'h340: r_mscratch <= w_new;
        12'h341: r_mepc <= {w_new[XLEN-1:2], 2'b00};
        12'h342: r_mcause <= w_new;
        12'h343: r_mtval <= w_new;
        12'h320: begin r_cy_inh <= w_new[0]; r_ir_inh <= w_new[2]; end
        default: ;
      endcase
    end
  end

  // Counters: a write to one half replaces that half and skips the increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      if (w_we && csr.addr_i == 12'hB00) begin
        if (XLEN == 32) r_cycle[31:0] <= 32'(w_new);
        else            r_cycle <= 64'(w_new);
      end else if (w_we && csr.addr_i == 12'hB80) begin
        r_cycle[63:32] <= 32'(w_new);
      end else if (!r_cy_inh) begin
        r_cycle <= r_cycle + 64'd1;
      end
      if (w_we && csr.addr_i == 12'hB02) begin
        if (XLEN == 32) r_instret[31:0] <= 32'(w_new);
        else            r_instret <= 64'(w_new);
      end else if (w_we && csr.addr_i == 12'hB82) begin
        r_instret[63:32] <= 32'(w_new);
      end else if (retire_i && !r_ir_inh) begin
        r_instret <= r_instret + 64'd1;
      end
    end
  end

  // One-flop synchroniser for the raw interrupt lines; these flops are mip.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_irq_ext <= 1'b0; r_irq_tmr <= 1'b0; r_irq_sw <= 1'b0;
    end else begin
      r_irq_ext <= irq_ext_i; r_irq_tmr <= irq_tmr_i; r_irq_sw <= irq_sw_i;
    end
  end
endmodule

// File: tb/tb_csr_mfile.sv
// Bench for csr_mfile (XLEN=32, HART_ID=3, VECTORED=1): directed vector table,
// hand-written trap/IRQ/counter sequences, then random traffic against a model.
module tb_csr_mfile;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        trap, mret, retire, irq_ext, irq_tmr, irq_sw;
  logic [31:0] trap_cause, trap_pc, trap_val;
  logic        irq_pending;
  logic [31:0] irq_cause, trap_vector, epc;

  csr_mfile_if #(.XLEN(XLEN)) bus();

  csr_mfile #(.XLEN(XLEN), .HART_ID(32'd3), .MISA_VAL(32'h40000100), .VECTORED(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .csr(bus),
    .trap_i(trap), .trap_cause_i(trap_cause), .trap_pc_i(trap_pc), .trap_val_i(trap_val),
    .mret_i(mret), .retire_i(retire),
    .irq_ext_i(irq_ext), .irq_tmr_i(irq_tmr), .irq_sw_i(irq_sw),
    .irq_pending_o(irq_pending), .irq_cause_o(irq_cause),
    .trap_vector_o(trap_vector), .epc_o(epc)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_minh;
  logic [2:0]  m_irq;  // {ext, tmr, sw} as seen one cycle late
  logic [63:0] m_cyc, m_ins;

  function automatic logic [31:0] m_mip();
    return (32'(m_irq[2]) << 11) | (32'(m_irq[1]) << 7) | (32'(m_irq[0]) << 3);
  endfunction

  function automatic void m_read(input logic [11:0] a, output bit kn, output bit ro,
                                 output logic [31:0] v);
    kn = 1; ro = 0; v = 0;
    case (a)
      12'hF11, 12'hF12, 12'hF13: ro = 1;
      12'hF14: begin ro = 1; v = 3; end
      12'h301: begin ro = 1; v = 32'h40000100; end
      12'h300: v = m_mstatus;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = m_mip();
      12'h320: v = m_minh;
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ins[31:0];
      12'hB82: v = m_ins[63:32];
      default: kn = 0;
    endcase
  endfunction

  function automatic bit m_illegal();
    bit kn, ro, wr; logic [31:0] v;
    m_read(bus.addr_i, kn, ro, v);
    wr = (bus.funct3_i[1:0] == 2'b01) || (bus.rs1_i != 0);
    return bus.csr_valid_i && (!kn || bus.funct3_i[1:0] == 2'b00 || (ro && wr));
  endfunction

  task automatic model_reset();
    m_mstatus = 32'h1800; m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0; m_minh = 0; m_irq = 0; m_cyc = 0; m_ins = 0;
  endtask

  // Applies one clock edge worth of architectural effect, using current inputs.
  task automatic model_apply();
    bit kn, ro, wr, dw; logic [31:0] old, nv; logic [63:0] nc, ni;
    if (rst) begin model_reset(); return; end
    m_read(bus.addr_i, kn, ro, old);
    wr = (bus.funct3_i[1:0] == 2'b01) || (bus.rs1_i != 0);
    dw = bus.csr_valid_i && !m_illegal() && wr && !trap && !mret;
    case (bus.funct3_i[1:0])
      2'b01:   nv = bus.wdata_i;
      2'b10:   nv = old | bus.wdata_i;
      default: nv = old & ~bus.wdata_i;
    endcase
    nc = m_minh[0] ? m_cyc : m_cyc + 1;
    ni = (retire && !m_minh[2]) ? m_ins + 1 : m_ins;
    if (dw) begin
      case (bus.addr_i)
        12'hB00: nc = {m_cyc[63:32], nv};
        12'hB80: nc = {nv, m_cyc[31:0]};
        12'hB02: ni = {m_ins[63:32], nv};
        12'hB82: ni = {nv, m_ins[31:0]};
        default: ;
      endcase
    end
    m_cyc = nc; m_ins = ni;
    if (trap) begin
      m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mtval = trap_val;
      m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
    end else if (mret) begin
      m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
    end else if (dw) begin
      case (bus.addr_i)
        12'h300: m_mstatus = 32'h1800 | (nv & 32'h88);
        12'h304: m_mie = nv & 32'h888;
        12'h305: m_mtvec = nv & ~32'h2;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'h320: m_minh = nv & 32'h5;
        default: ;
      endcase
    end
    m_irq = {irq_ext, irq_tmr, irq_sw};
  endtask

  task automatic check_model();
    bit kn, ro, ill, pend; logic [31:0] v, pb, code, base, vec;
    m_read(bus.addr_i, kn, ro, v);
    ill = m_illegal();
    chk("m_rdata", bus.rdata_o, (bus.csr_valid_i && !ill) ? v : 32'h0);
    chk("m_illegal", bus.illegal_o, ill);
    pb = m_mip() & m_mie;
    pend = m_mstatus[3] && (pb != 0);
    code = pb[11] ? 11 : pb[3] ? 3 : pb[7] ? 7 : 0;
    base = m_mtvec & ~32'h3;
    vec = (m_mtvec[0] && pend) ? base + 4 * code : base;
    chk("m_pending", irq_pending, pend);
    chk("m_cause", irq_cause, pend ? (32'h80000000 | code) : 32'h0);
    chk("m_vector", trap_vector, vec);
    chk("m_epc", epc, m_mepc);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge with inputs set; optionally checks, then crosses one edge.
  task automatic run_cycle(input bit do_chk);
    #2;
    if (do_chk) check_model();
    @(posedge clk);
    model_apply();
    @(negedge clk);
  endtask

  task automatic set_op(input logic [2:0] f3, input logic [11:0] a,
                        input logic [4:0] r1, input logic [31:0] wd);
    bus.csr_valid_i = 1'b1; bus.funct3_i = f3; bus.addr_i = a;
    bus.rs1_i = r1; bus.wdata_i = wd;
  endtask

  task automatic idle_op();
    bus.csr_valid_i = 1'b0; bus.funct3_i = 3'd0; bus.addr_i = 12'd0;
    bus.rs1_i = 5'd0; bus.wdata_i = 32'd0;
  endtask

  task automatic csr_do(input logic [2:0] f3, input logic [11:0] a,
                        input logic [4:0] r1, input logic [31:0] wd);
    set_op(f3, a, r1, wd);
    run_cycle(1);
    idle_op();
  endtask

  task automatic exp_read(input string nm, input logic [11:0] a, input logic [31:0] exp);
    set_op(3'b010, a, 5'd0, 32'd0);
    #1 chk(nm, bus.rdata_o, exp);
    run_cycle(1);
    idle_op();
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  rs1;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];
  logic [11:0] addr_pool[18] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h340,
                                 12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02,
                                 12'hB80, 12'hB82, 12'hF11, 12'hF14, 12'h7C0, 12'hB01};

  initial begin
    idle_op();
    trap = 0; mret = 0; retire = 0; irq_ext = 0; irq_tmr = 0; irq_sw = 0;
    trap_cause = 0; trap_pc = 0; trap_val = 0;
    model_reset();

    vecs.push_back('{3'b010, 12'h300, 5'd0, 32'h0,        32'h00001800, 1'b0});
    vecs.push_back('{3'b010, 12'hF14, 5'd0, 32'h0,        32'h3,        1'b0});
    vecs.push_back('{3'b010, 12'h7C0, 5'd0, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{3'b001, 12'h340, 5'd1, 32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{3'b010, 12'h340, 5'd0, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{3'b011, 12'h340, 5'd2, 32'h000000FF, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{3'b010, 12'h340, 5'd0, 32'h0,        32'hDEADBE00, 1'b0});
    vecs.push_back('{3'b101, 12'hF14, 5'd5, 32'h5,        32'h0,        1'b1});
    vecs.push_back('{3'b010, 12'hF14, 5'd0, 32'h0,        32'h3,        1'b0});
    vecs.push_back('{3'b001, 12'h341, 5'd1, 32'h1003,     32'h0,        1'b0});
    vecs.push_back('{3'b010, 12'h341, 5'd0, 32'h0,        32'h1000,     1'b0});
    vecs.push_back('{3'b010, 12'h301, 5'd0, 32'h0,        32'h40000100, 1'b0});
    vecs.push_back('{3'b001, 12'h301, 5'd1, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{3'b001, 12'h300, 5'd1, 32'hFFFFFFFF, 32'h1800,     1'b0});
    vecs.push_back('{3'b010, 12'h300, 5'd0, 32'h0,        32'h1888,     1'b0});
    vecs.push_back('{3'b011, 12'h300, 5'd1, 32'h8,        32'h1888,     1'b0});
    vecs.push_back('{3'b010, 12'h300, 5'd0, 32'h0,        32'h1880,     1'b0});
    vecs.push_back('{3'b001, 12'h304, 5'd1, 32'hFFFFFFFF, 32'h0,        1'b0});
    vecs.push_back('{3'b010, 12'h304, 5'd0, 32'h0,        32'h888,      1'b0});
    vecs.push_back('{3'b001, 12'h305, 5'd1, 32'hFFFFFFFF, 32'h0,        1'b0});
    vecs.push_back('{3'b010, 12'h305, 5'd0, 32'h0,        32'hFFFFFFFD, 1'b0});
    vecs.push_back('{3'b000, 12'h340, 5'd1, 32'h1,        32'h0,        1'b1});

    // Reset
    run_cycle(0);
    run_cycle(0);
    rst = 1'b0;
    #1;
    chk("rst_rdata", bus.rdata_o, 32'h0);
    chk("rst_illegal", bus.illegal_o, 1'b0);
    chk("rst_pending", irq_pending, 1'b0);
    chk("rst_cause", irq_cause, 32'h0);
    chk("rst_vector", trap_vector, 32'h0);
    chk("rst_epc", epc, 32'h0);

    // Directed vector table
    foreach (vecs[i]) begin
      set_op(vecs[i].f3, vecs[i].addr, vecs[i].rs1, vecs[i].wd);
      #1;
      chk($sformatf("vec%0d_rdata", i), bus.rdata_o, vecs[i].exp_rd);
      chk($sformatf("vec%0d_illegal", i), bus.illegal_o, vecs[i].exp_ill);
      run_cycle(1);
    end
    idle_op();

    // Interrupts: MIE on, mie already 0x888, vectored mtvec at 0x100
    csr_do(3'b010, 12'h300, 5'd1, 32'h8);
    csr_do(3'b001, 12'h305, 5'd1, 32'h101);
    irq_tmr = 1; irq_ext = 1;
    #1 chk("irq_not_yet", irq_pending, 1'b0);
    run_cycle(1);
    #1;
    chk("irq_pending", irq_pending, 1'b1);
    chk("irq_cause_mei", irq_cause, 32'h8000000B);
    chk("irq_vector_mei", trap_vector, 32'h12C);
    irq_ext = 0;
    run_cycle(1);
    #1;
    chk("irq_cause_mti", irq_cause, 32'h80000007);
    chk("irq_vector_mti", trap_vector, 32'h11C);
    irq_tmr = 0;
    run_cycle(1);
    #1;
    chk("irq_dropped", irq_pending, 1'b0);
    chk("irq_vector_base", trap_vector, 32'h100);

    // Trap and MRET together, with a CSR write that must be dropped
    csr_do(3'b011, 12'h300, 5'd1, 32'h80);  // MPIE=0, MIE=1
    set_op(3'b001, 12'h340, 5'd1, 32'h777);
    trap = 1; mret = 1; trap_pc = 32'h2002; trap_cause = 32'h2; trap_val = 32'h55;
    run_cycle(1);
    trap = 0; mret = 0;
    idle_op();
    #1 chk("trap_epc", epc, 32'h2000);
    exp_read("trap_mstatus", 12'h300, 32'h1880);
    exp_read("trap_mcause", 12'h342, 32'h2);
    exp_read("trap_mtval", 12'h343, 32'h55);
    exp_read("trap_drop_wr", 12'h340, 32'hDEADBE00);
    mret = 1;
    run_cycle(1);
    mret = 0;
    exp_read("mret_mstatus", 12'h300, 32'h1888);

    // mcycle carry into mcycleh
    csr_do(3'b001, 12'hB80, 5'd1, 32'h0);
    csr_do(3'b001, 12'hB00, 5'd1, 32'hFFFFFFFF);
    exp_read("cyc_hi_before", 12'hB80, 32'h0);
    exp_read("cyc_lo_wrap", 12'hB00, 32'h0);
    exp_read("cyc_hi_carry", 12'hB80, 32'h1);
    // Inhibit freezes the count
    csr_do(3'b010, 12'h320, 5'd1, 32'h1);
    csr_do(3'b001, 12'hB00, 5'd1, 32'h1234);
    exp_read("cyc_frozen1", 12'hB00, 32'h1234);
    exp_read("cyc_frozen2", 12'hB00, 32'h1234);
    csr_do(3'b011, 12'h320, 5'd1, 32'h1);
    // Write beats the increment in the same cycle
    csr_do(3'b001, 12'hB00, 5'd1, 32'h50);
    exp_read("cyc_write_wins", 12'hB00, 32'h50);
    exp_read("cyc_runs", 12'hB00, 32'h51);
    // minstret write beats retire, then counts retires
    retire = 1;
    csr_do(3'b001, 12'hB02, 5'd1, 32'h10);
    retire = 0;
    exp_read("ins_write_wins", 12'hB02, 32'h10);
    retire = 1;
    exp_read("ins_pre_inc", 12'hB02, 32'h10);
    retire = 0;
    exp_read("ins_counted", 12'hB02, 32'h11);

    // Reset in the middle of a trap and a write
    set_op(3'b001, 12'h340, 5'd1, 32'h99);
    trap = 1; trap_pc = 32'h4000; rst = 1;
    run_cycle(0);
    trap = 0; rst = 0;
    idle_op();
    #1 chk("rst2_epc", epc, 32'h0);
    exp_read("rst2_mstatus", 12'h300, 32'h1800);
    exp_read("rst2_mscratch", 12'h340, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      set_op(3'($urandom_range(0, 7)), addr_pool[$urandom_range(0, 17)],
             5'($urandom_range(0, 3)), $urandom());
      if ($urandom_range(0, 3) == 0) idle_op();
      trap = ($urandom_range(0, 15) == 0);
      mret = ($urandom_range(0, 15) == 0);
      trap_cause = $urandom(); trap_pc = $urandom(); trap_val = $urandom();
      retire = $urandom_range(0, 1);
      irq_ext = ($urandom_range(0, 3) == 0);
      irq_tmr = ($urandom_range(0, 2) == 0);
      irq_sw  = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 199) == 0);
      run_cycle(1);
    end
    rst = 0; trap = 0; mret = 0; idle_op();
    run_cycle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csr_mfile.md
# csr_mfile

Parametrised machine-mode CSR file for the RV32/RV64 core. It sits beside the execute stage: it serves Zicsr read/modify/write accesses, records trap entry and MRET state, and runs free-running cycle/instret counters. It also synchronises the interrupt lines, prioritises them, and supplies the trap-vector and return addresses to the fetch stage.

## Interface
- XLEN, 32, data width; 32 or 64 only
- HART_ID, 0, value returned by mhartid
- MISA_VAL, 32'h40000100, misa read value (RV32I); for XLEN=64 the MXL field reads 2
- VECTORED, 1, 1 allows mtvec.MODE=1 (vectored interrupts); 0 forces MODE to read 0
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- csr_valid_i  in  1  CSR instruction in execute this cycle
- funct3_i  in  3  Zicsr funct3; bit2 selects the immediate form
- addr_i  in  12  CSR address
- rs1_i  in  5  rs1 index or zimm field, used for write suppression
- wdata_i  in  XLEN  rs1 value or zero-extended zimm
- rdata_o  out  XLEN  old CSR value; 0 when not valid or illegal
- illegal_o  out  1  illegal CSR access
- trap_i  in  1  take trap this cycle
- trap_cause_i  in  XLEN  mcause value; MSB set = interrupt
- trap_pc_i  in  XLEN  PC to save in mepc
- trap_val_i  in  XLEN  mtval value
- mret_i  in  1  MRET executing
- retire_i  in  1  one instruction retired
- irq_ext_i, irq_tmr_i, irq_sw_i  in  1 each  raw level interrupt lines
- irq_pending_o  out  1  interrupt enabled and pending
- irq_cause_o  out  XLEN  cause of the highest-priority pending interrupt
- trap_vector_o  out  XLEN  trap target address
- epc_o  out  XLEN  mepc, the MRET target

## Operation
- Implemented CSRs: misa, mvendorid/marchid/mimpid (read 0), mhartid, mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip, mcountinhibit (0x320), mcycle, minstret; mcycleh/minstreth exist only when XLEN=32.
- Any other address with csr_valid_i -> illegal_o=1, no state change.
- Read-only addresses (0xF11-0xF14, misa) accept reads. Any write attempt to them -> illegal.
- Write enable: CSRRW/CSRRWI always writes. CSRRS/CSRRC/CSRRSI/CSRRCI write only when rs1_i≠0.
- New value: W -> wdata_i; S -> old|wdata_i; C -> old&~wdata_i. The result is then masked per register.
- mstatus: only MIE(3), MPIE(7) and MPP(12:11) are writable. MPP is hardwired 2'b11.
- mie: only bits 11, 7 and 3 are writable.
- mip: read-only. Bits 11, 7 and 3 come from the synchroniser flops.
- mepc: bits [1:0] are forced to 0 on every write.
- mtvec: the BASE field is writable. MODE bit 0 is writable only when VECTORED=1; bit 1 is forced to 0.
- mcountinhibit: bits 0 (CY) and 2 (IR) are writable.
- Trap entry (trap_i):
  - mepc <= trap_pc_i & ~3; mcause <= trap_cause_i; mtval <= trap_val_i.
  - MPIE <= MIE; MIE <= 0.
- mret_i: MIE <= MPIE; MPIE <= 1.
- Same-cycle priority: trap_i > mret_i > CSR write. Each lower-priority update is dropped.
- Counters are 64-bit.
  - mcycle increments each cycle unless CY=1.
  - minstret increments on retire_i unless IR=1.
  - A CSR write to any half takes precedence over the increment that cycle and replaces only that half.
  - Wrap from 2^64-1 to 0 with no flag.
- Interrupt priority: MEI > MSI > MTI.
  - irq_pending_o = MIE & |(mip & mie).
  - irq_cause_o = {1, cause}, with cause 11, 3 or 7.
- trap_vector_o:
  - = {BASE,2'b00} when MODE=0, or when the trap cause is an exception.
  - = BASE + 4*cause when MODE=1 and irq_pending_o=1; the cause is taken from irq_cause_o.

## Timing
- rdata_o, illegal_o, epc_o, trap_vector_o, irq_pending_o and irq_cause_o are combinational from current state.
- Reads return the pre-write, pre-increment value.
- All state updates occur at the clk_i edge and are visible the next cycle.
- IRQ lines pass through one flop into mip, so irq_pending_o rises 1 cycle after an enabled line rises.
- Reset values:
  - mstatus = 0x1800; mie, mip sync flops, mtvec, mscratch, mepc, mcause, mtval, mcountinhibit and counters = 0.
  - All outputs reset to 0, except trap_vector_o = 0 and epc_o = 0.
- Reset asserted mid-operation overrides trap, mret, write and increment in that cycle.

## Test plan
- After reset, read 0x300 -> 0x00001800; read 0xF14 with HART_ID=3 -> 3; read 0x7C0 -> illegal_o=1 and rdata_o=0.
- CSRRW mscratch 0xDEADBEEF, then CSRRS with rs1=0 -> reads 0xDEADBEEF with no write; CSRRC of 0xFF -> next read 0xDEADBE00.
- CSRRWI to mhartid -> illegal_o=1, mhartid unchanged. CSRRW mepc 0x1003 -> reads 0x1000.
- Set MIE=1 and mie=0x888, raise irq_tmr_i and irq_ext_i together -> one cycle later irq_pending_o=1 with cause 0x8000000B. With mtvec=0x101 -> trap_vector_o=0x12C.
- Assert trap_i and mret_i in the same cycle with MIE=1 -> MPIE=1, MIE=0, mepc=trap_pc_i. A following mret_i -> MIE=1.
- Write mcycle=0xFFFFFFFF with mcycleh=0 (XLEN=32) -> one cycle later mcycleh=1 and mcycle=0. Set CY -> count frozen. Write mcycle in the same cycle as an increment -> the written value wins.
